// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// oversampling constants. The PARITY state exists only when the build
// defines UART_RX_PARITY_EN.
package uart_pkg;

  localparam int OS_RATE    = 16;
  localparam int SAMPLE_MID = 8;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Received-byte buffer. Pointers carry one extra wrap bit so full and empty
// are distinguished without a separate count. A push while full is accepted
// only when a pop happens in the same cycle (the freed slot is reused).
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic                 i_pop,
  output logic [DATA_BITS-1:0] o_rdata,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic                 w_we;
  logic                 w_re;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_re    = i_pop & ~o_empty;
  assign w_we    = i_push & (~o_full | w_re);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer advance on accepted push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_re) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until a pointer covers them
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop input synchronizer, free-running 16x oversample tick,
// frame FSM (IDLE/START/DATA/[PARITY]/STOP) and a byte FIFO with a
// valid/ready consumer interface. Errors are reported as one-clock pulses.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN; without it
// DATA goes straight to STOP and parity_err is tied low.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx;
  logic [DIV_W-1:0]     r_div;
  logic                 w_tick;
  uart_state_e          r_state;
  uart_state_e          w_state_nxt;
  logic [3:0]           r_os;
  logic [2:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_os_mid;
  logic                 w_os_last;
  logic                 w_par_ok;
  logic                 w_stop_smp;
  logic                 w_push;
  logic                 w_frame_c;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 r_frame_err;
  logic                 r_overrun_err;

  assign w_rx      = r_sync2;
  assign w_tick    = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_os_mid  = (r_os == 4'(SAMPLE_MID - 1));
  assign w_os_last = (r_os == 4'(OS_RATE - 1));

  // Two-flop synchronizer for the asynchronous line, idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running oversample tick divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_div <= '0;
    else     r_div <= w_tick ? '0 : r_div + 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic; every transition waits for an oversample tick
  always_comb begin
    w_state_nxt = r_state;
    if (w_tick) begin
      case (r_state)
        ST_IDLE:   if (!w_rx) w_state_nxt = ST_START;
        ST_START:  if (w_os_mid) w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
        ST_DATA:   if (w_os_last && (r_bit == 3'(DATA_BITS - 1)))
`ifdef UART_RX_PARITY_EN
                     w_state_nxt = ST_PARITY;
        ST_PARITY: if (w_os_last) w_state_nxt = ST_STOP;
`else
                     w_state_nxt = ST_STOP;
`endif
        ST_STOP:   if (w_os_last) w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: busy flag and the stop-bit verdict (push or framing error)
  always_comb begin
    rx_busy    = (r_state != ST_IDLE);
    w_stop_smp = w_tick && (r_state == ST_STOP) && w_os_last;
    w_push     = w_stop_smp && w_rx && w_par_ok;
    w_frame_c  = w_stop_smp && !w_rx;
  end

  // Oversample/bit counters and LSB-first shift register, advanced on ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_os    <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          r_os  <= '0;
          r_bit <= '0;
        end
        ST_START: r_os <= w_os_mid ? '0 : r_os + 4'd1;
        ST_DATA: begin
          if (w_os_last) begin
            r_os    <= '0;
            r_bit   <= r_bit + 3'd1;
            r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
          end else begin
            r_os <= r_os + 4'd1;
          end
        end
        default: r_os <= w_os_last ? '0 : r_os + 4'd1;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic w_par_c;
  logic r_parity_err;

  // Even-parity verdict captured mid parity bit, held until the stop bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_bad <= 1'b0;
    end else if (w_tick) begin
      if (r_state == ST_IDLE)
        r_par_bad <= 1'b0;
      else if ((r_state == ST_PARITY) && w_os_last)
        r_par_bad <= ^{w_rx, r_shift};
    end
  end

  assign w_par_ok = !r_par_bad;
  assign w_par_c  = w_stop_smp && r_par_bad;

  // Parity error pulse, reported together with the stop-bit sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_parity_err <= 1'b0;
    else     r_parity_err <= w_par_c;
  end

  assign parity_err = r_parity_err;
`else
  assign w_par_ok   = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign w_pop   = m_valid & m_ready;
  assign m_valid = ~w_empty;

  uart_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (w_pop),
    .o_rdata (m_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Registered one-clock error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_frame_err   <= w_frame_c;
      r_overrun_err <= w_push && w_full && !w_pop;
    end
  end

  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl (CLK_DIV=4 -> 64 clk per bit,
// FIFO_DEPTH=4). Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx_ctrl;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CLK    = CLK_DIV * 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  uart_rx_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  // Monitor: records accepted bytes and pulse statistics on the falling edge
  logic [7:0] got_arr [0:255];
  int got_n = 0, mv_cyc = 0, busy_cyc = 0, hold_viol = 0;
  int fe_p = 0, fe_c = 0, ov_p = 0, ov_c = 0, pe_p = 0, pe_c = 0;
  logic prev_fe = 1'b0, prev_ov = 1'b0, prev_pe = 1'b0, prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        got_arr[got_n[7:0]] <= m_data;
        got_n <= got_n + 1;
      end
      if (m_valid) mv_cyc <= mv_cyc + 1;
      if (rx_busy) busy_cyc <= busy_cyc + 1;
      if (frame_err) fe_c <= fe_c + 1;
      if (frame_err && !prev_fe) fe_p <= fe_p + 1;
      if (overrun_err) ov_c <= ov_c + 1;
      if (overrun_err && !prev_ov) ov_p <= ov_p + 1;
      if (parity_err) pe_c <= pe_c + 1;
      if (parity_err && !prev_pe) pe_p <= pe_p + 1;
      if (prev_hold && m_valid && (m_data !== prev_data)) hold_viol <= hold_viol + 1;
    end
    prev_fe   <= frame_err;
    prev_ov   <= overrun_err;
    prev_pe   <= parity_err;
    prev_hold <= m_valid && !m_ready;
    prev_data <= m_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_in = bits[i];
      wait_clk(BIT_CLK);
    end
    rx_in = 1'b1;
  endtask

  // Well-formed frame (correct even parity when the parity build is used)
  task automatic send_frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    send_raw({stop, ^d, d, 1'b0}, 11);
`else
    send_raw({1'b0, stop, d, 1'b0}, 11 - 1);
`endif
  endtask

  // Reference: bytes the consumer should see, in order
  logic [7:0] exp_q[$];
  int b_got, b_mv, b_fe, b_fec, b_ov, b_ovc, b_pe, b_pec, b_busy;

  task automatic snap();
    b_got = got_n; b_mv = mv_cyc; b_fe = fe_p; b_fec = fe_c;
    b_ov = ov_p; b_ovc = ov_c; b_pe = pe_p; b_pec = pe_c; b_busy = busy_cyc;
    exp_q.delete();
  endtask

  task automatic chk_bytes(input string tag);
    chk({tag, "_count"}, 32'(got_n - b_got), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_n - b_got; i++)
      chk({tag, "_byte"}, {24'h0, got_arr[(b_got + i) % 256]}, {24'h0, exp_q[i]});
  endtask

  task automatic chk_errs(input string tag, input int fe, input int ov, input int pe);
    chk({tag, "_frame_err"},   32'(fe_p - b_fe), 32'(fe));
    chk({tag, "_overrun_err"}, 32'(ov_p - b_ov), 32'(ov));
    chk({tag, "_parity_err"},  32'(pe_p - b_pe), 32'(pe));
    chk({tag, "_pulse_width"}, 32'((fe_c - b_fec) + (ov_c - b_ovc) + (pe_c - b_pec)),
        32'(fe + ov + pe));
  endtask

  logic [7:0] d;
  logic [7:0] d77;
  int n;

  initial begin
    rst = 1'b1; rx_in = 1'b1; m_ready = 1'b1;
    wait_clk(5);
    chk("rst_m_valid", {31'h0, m_valid}, 32'h0);
    chk("rst_rx_busy", {31'h0, rx_busy}, 32'h0);
    chk("rst_errs", {29'h0, frame_err, overrun_err, parity_err}, 32'h0);
    rst = 1'b0;
    wait_clk(BIT_CLK);

    // Single good frame with a ready consumer
    snap();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_clk(8);
    chk_bytes("a5");
    chk("a5_valid_cycles", 32'(mv_cyc - b_mv), 32'd1);
    chk_errs("a5", 0, 0, 0);

    // Stop bit low: framing error, nothing delivered
    snap();
    send_frame(8'h3C, 1'b0);
    wait_clk(2 * BIT_CLK);
    chk_bytes("3c");
    chk("3c_valid_cycles", 32'(mv_cyc - b_mv), 32'd0);
    chk_errs("3c", 1, 0, 0);

    // Short low glitches at four tick phases
    snap();
    for (int ph = 0; ph < 4; ph++) begin
      rx_in = 1'b0;
      wait_clk(3);
      rx_in = 1'b1;
      wait_clk(100 + ph);
    end
    chk("glitch_busy_seen", {31'h0, busy_cyc > b_busy}, 32'h1);
    chk("glitch_busy_idle", {31'h0, rx_busy}, 32'h0);
    chk_bytes("glitch");
    chk_errs("glitch", 0, 0, 0);

    // Random back-to-back frames
    snap();
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(255, 0));
      exp_q.push_back(d);
      send_frame(d, 1'b1);
    end
    wait_clk(8);
    chk_bytes("rand");
    chk_errs("rand", 0, 0, 0);

    // Stalled consumer: 0x01..0x05 then 4..7 random bytes
    for (int pass = 0; pass < 2; pass++) begin
      snap();
      m_ready = 1'b0;
      n = (pass == 0) ? 5 : int'($urandom_range(FIFO_DEPTH + 3, FIFO_DEPTH));
      for (int i = 0; i < n; i++) begin
        d = (pass == 0) ? 8'(i + 1) : 8'($urandom_range(255, 0));
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
        send_frame(d, 1'b1);
      end
      wait_clk(8);
      chk("stall_m_valid", {31'h0, m_valid}, 32'h1);
      chk("stall_m_data", {24'h0, m_data}, {24'h0, exp_q[0]});
      chk("stall_no_pop", 32'(got_n - b_got), 32'd0);
      chk_errs("stall", 0, (n > FIFO_DEPTH) ? n - FIFO_DEPTH : 0, 0);
      m_ready = 1'b1;
      wait_clk(10);
      chk_bytes("drain");
      chk("drain_empty", {31'h0, m_valid}, 32'h0);
      chk("hold_stable", 32'(hold_viol), 32'd0);
    end

    // Reset in the middle of bit 4 of 0x77 with a byte already buffered
    snap();
    m_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    wait_clk(8);
    chk("prerst_m_valid", {31'h0, m_valid}, 32'h1);
    d77 = 8'h77;
    rx_in = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx_in = d77[i];
      wait_clk(BIT_CLK);
    end
    rx_in = d77[4];
    wait_clk(BIT_CLK / 2);
    chk("midframe_busy", {31'h0, rx_busy}, 32'h1);
    rst = 1'b1;
    wait_clk(3);
    chk("midrst_m_valid", {31'h0, m_valid}, 32'h0);
    chk("midrst_rx_busy", {31'h0, rx_busy}, 32'h0);
    rx_in = 1'b1;
    m_ready = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(BIT_CLK);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    wait_clk(8);
    chk_bytes("after_rst");
    chk_errs("after_rst", 0, 0, 0);

`ifdef UART_RX_PARITY_EN
    // 0x03 has even weight: parity bit 1 is wrong, 0 is right
    snap();
    send_raw({1'b1, 1'b1, 8'h03, 1'b0}, 11);
    wait_clk(8);
    chk_bytes("par_bad");
    chk_errs("par_bad", 0, 0, 1);
    snap();
    exp_q.push_back(8'h03);
    send_raw({1'b1, 1'b0, 8'h03, 1'b0}, 11);
    wait_clk(8);
    chk_bytes("par_good");
    chk_errs("par_good", 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 27, clk cycles per 16x-oversample tick (50 MHz / 115200 baud / 16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, received-byte buffer entries (power of two, >= 2).
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk in, rst in.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 rx_in  input  1  raw serial line, idle high, asynchronous to clk.
REQ-007 m_data  output  8  byte at FIFO head.
REQ-008 m_valid  output  1  FIFO non-empty.
REQ-009 m_ready  input  1  consumer accepts m_data when m_valid & m_ready.
REQ-010 rx_busy  output  1  frame in progress (state != IDLE).
REQ-011 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 overrun_err  output  1  one-cycle pulse: good byte dropped, FIFO full.
REQ-013 parity_err  output  1  one-cycle pulse: parity mismatch (constant 0 without macro).

Function
REQ-014 rx_in SHALL pass a 2-flop synchronizer (flops reset to 1) before any use.
REQ-015 Tick counter SHALL count 0..CLK_DIV-1 and assert os_tick for one clk at CLK_DIV-1, free-running.
REQ-016 FSM states: IDLE, START, DATA, PARITY (macro only), STOP; all counting advances only on os_tick.
REQ-017 IDLE: synchronized rx low on os_tick -> START, oversample count cleared.
REQ-018 START: at 8th tick sample; low -> DATA, high -> IDLE (glitch, no error flag).
REQ-019 DATA: sample every 16 ticks, LSB first into shift register; after bit 7 -> PARITY or STOP.
REQ-020 STOP: sample after 16 ticks; high and no parity error -> push byte; low -> frame_err pulse, byte dropped; always -> IDLE.
REQ-021 Push with FIFO full and no same-cycle pop SHALL drop new byte, pulse overrun_err, keep FIFO unchanged.
REQ-022 Push and pop in same cycle SHALL both succeed, including when full.
REQ-023 m_valid SHALL rise the clk after the push cycle; m_data SHALL hold stable while m_valid & !m_ready.
REQ-024 Pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSBs differ, low bits equal.
REQ-025 Back-to-back frames: IDLE SHALL accept a new start edge on the first tick after STOP.

Reset
REQ-026 On rst: state IDLE, counters 0, pointers 0, shift register 0, m_valid 0, rx_busy 0, all error pulses 0, synchronizer 1.
REQ-027 Reset mid-frame SHALL discard the partial byte and FIFO contents; no error pulse on release.

Configuration
REQ-028 Macro UART_RX_PARITY_EN: defined -> PARITY state samples a 9th bit after 16 ticks; even-parity mismatch pulses parity_err and drops byte at STOP.
REQ-029 Undefined -> no PARITY state, DATA goes directly to STOP, parity_err tied 0.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state enum, OS_RATE=16, SAMPLE_MID=8, DATA_BITS=8.
REQ-031 FIFO SHALL be sub-module uart_byte_fifo (push/pop/full/empty, FIFO_DEPTH parameter).

Verification (CLK_DIV=4, 64 clk/bit)
REQ-032 Frame 0xA5, stop 1, m_ready=1 -> m_data=0xA5, m_valid one clk, no errors.
REQ-033 Frame 0x3C with stop bit 0 -> frame_err one pulse, m_valid stays 0.
REQ-034 rx_in low 3 clk pulse while idle -> returns IDLE, rx_busy briefly 1, no output, no error.
REQ-035 m_ready=0, send 5 bytes 0x01..0x05 -> FIFO holds 0x01..0x04, overrun_err on 5th; drain yields 0x01..0x04 in order.
REQ-036 rst asserted mid-bit 4 of 0x77, then frame 0x12 -> only 0x12 delivered.
REQ-037 With UART_RX_PARITY_EN, 0x03 with parity bit 1 -> parity_err pulse, no m_valid; parity bit 0 -> 0x03 delivered.
